aes128_enc_iter: RTL



---
 rtl/aes_pkg.sv | 78 +++++++
 rtl/aes_key_step.sv | 26 ++
 rtl/aes128_enc_iter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, FSM state type and byte/column helpers
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    gmul2 = xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    gmul3 = xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  // Column c of a 128-bit state; byte 0 of the block sits in [127:120].
  function automatic logic [31:0] col_of(input logic [127:0] s, input logic [1:0] c);
    case (c)
      2'd0:    col_of = s[127:96];
      2'd1:    col_of = s[95:64];
      2'd2:    col_of = s[63:32];
      default: col_of = s[31:0];
    endcase
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    mix_col = {gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
               a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
               a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
               gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - combinational AES-128 key expansion step (one round key from the previous)
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] next_rk
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk;

  // RotWord then SubWord of the last word, with rcon folded into the leading byte.
  assign t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_rk = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_enc_iter.sv
// rtl/aes128_enc_iter.sv - iterative AES-128 encryptor, COLS columns per cycle, ECB/CBC with valid/ready
module aes128_enc_iter
  import aes_pkg::*;
#(
  parameter int COLS = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         in_cbc,
  input  logic         iv_we,
  input  logic [127:0] iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int         S         = 4 / COLS;
  localparam logic [1:0] LAST_STEP = 2'(S - 1);
  localparam logic [1:0] COLS_W    = 2'(COLS % 4);

  state_t       state;
  logic [3:0]   round;
  logic [1:0]   step;
  logic [127:0] state_reg;
  logic [127:0] next_reg;
  logic [127:0] rk;
  logic [127:0] chain;
  logic         cbc_reg;

  logic [127:0] cur_rk;
  logic [7:0]   round_rcon;
  logic [127:0] chain_eff;
  logic [127:0] next_full;
  logic [1:0]   col_idx [COLS];
  logic [31:0]  col_out [COLS];

  assign round_rcon = rcon_of(round);
  assign chain_eff  = iv_we ? iv : chain;
  assign out_data   = state_reg;

  aes_key_step u_key_step (
    .rk      (rk),
    .rcon    (round_rcon),
    .next_rk (cur_rk)
  );

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [7:0]  sb [4];
    logic [31:0] shifted;
    logic [31:0] mixed;

    assign col_idx[c] = step * COLS_W + 2'(c);

    // ShiftRows: row r of output column j comes from input column (j + r) mod 4.
    for (genvar r = 0; r < 4; r++) begin : g_row
      logic [31:0] src;
      assign src   = col_of(state_reg, col_idx[c] + 2'(r));
      assign sb[r] = sbox(src[31-8*r -: 8]);
    end

    assign shifted    = {sb[0], sb[1], sb[2], sb[3]};
    assign mixed      = (round == 4'(NR)) ? shifted : mix_col(shifted);
    assign col_out[c] = mixed ^ col_of(cur_rk, col_idx[c]);
  end

  always_comb begin
    next_full = next_reg;
    for (int c = 0; c < COLS; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (col_idx[c] == 2'(k)) next_full[127-32*k -: 32] = col_out[c];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      round     <= '0;
      step      <= '0;
      state_reg <= '0;
      next_reg  <= '0;
      rk        <= '0;
      chain     <= '0;
      cbc_reg   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iv_we) chain <= iv;
          if (in_valid) begin
            state_reg <= in_data ^ in_key ^ (in_cbc ? chain_eff : '0);
            rk        <= in_key;
            cbc_reg   <= in_cbc;
            round     <= 4'd1;
            step      <= 2'd0;
            state     <= ROUND;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ROUND: begin
          next_reg <= next_full;
          if (step == LAST_STEP) begin
            state_reg <= next_full;
            rk        <= cur_rk;
            step      <= 2'd0;
            if (round == 4'(NR)) begin
              state     <= OUT;
              out_valid <= 1'b1;
            end else begin
              round <= round + 4'd1;
            end
          end else begin
            step <= step + 2'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (cbc_reg) chain <= state_reg;
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
